// File: rtl/fifo_word_unpacker.sv
// Drains a synchronous FIFO one word at a time and replays each word as a
// sequence of BYTE_W-wide beats on a valid/ready stream.
module fifo_word_unpacker #(
    parameter int DATA_W    = 32,
    parameter int BYTE_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [DATA_W-1:0]   word_reg, word_next;
    logic [BYTE_W-1:0]   lane [NB];
    logic [IDX_W-1:0]    lane_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane[gi] = word_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Byte order is a pure index remap; the counter always runs upward.
    assign lane_sel = MSB_FIRST ? (LAST_IDX - idx_reg) : idx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            word_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        word_next  = word_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                word_next  = fifo_dout;
                idx_next   = '0;
                state_next = SEND;
            end
            SEND: begin
                if (byte_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        // Chain straight into the next fetch to keep one bubble per word.
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            fifo_pop = 1'b0;
        end
    end

    assign byte_valid = (state_reg == SEND);
    assign byte_last  = byte_valid && (idx_reg == LAST_IDX);
    assign byte_out   = byte_valid ? lane[lane_sel] : '0;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Bench for fifo_word_unpacker: an LSB-first and an MSB-first instance share one
// modelled FIFO and are checked against a queue of expected bytes.
module tb_fifo_word_unpacker;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_dout = '0;
    logic        byte_ready = 1'b0;

    logic        pop_l, pop_m;
    logic [7:0]  byte_l, byte_m;
    logic        valid_l, valid_m, last_l, last_m, busy_l, busy_m;

    always #5 clk = ~clk;

    fifo_word_unpacker #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_pop(pop_l),
        .fifo_dout(fifo_dout), .byte_out(byte_l), .byte_valid(valid_l),
        .byte_ready(byte_ready), .byte_last(last_l), .busy(busy_l)
    );

    fifo_word_unpacker #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_pop(pop_m),
        .fifo_dout(fifo_dout), .byte_out(byte_m), .byte_valid(valid_m),
        .byte_ready(byte_ready), .byte_last(last_m), .busy(busy_m)
    );

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        bit         last;
        bit         first;
    } exp_t;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pop_count = 0;
    int xfer_count = 0;
    int last_pop_cyc = 0;
    int prev_xfer_cyc = 0;
    bit strict = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_xfer = 1'b0;
    logic [7:0] prev_byte = '0;
    bit prev_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // The expected stream is built directly from the word value and byte order.
    task automatic push_word(input logic [31:0] w);
        exp_t e;
        for (int i = 0; i < NB; i++) begin
            e.lsb   = 8'((w >> (8 * i)) & 32'hFF);
            e.msb   = 8'((w >> (8 * (NB - 1 - i))) & 32'hFF);
            e.last  = (i == NB - 1);
            e.first = (i == 0);
            exp_q.push_back(e);
        end
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        bit   xfer;
        check("pop_vs_empty", 32'(pop_l & fifo_empty), 32'd0);
        check("pop_pair", 32'(pop_m), 32'(pop_l));
        check("valid_pair", 32'(valid_m), 32'(valid_l));
        if (rst) begin
            prev_valid = 1'b0;
            return;
        end
        xfer = valid_l && byte_ready;
        if (pop_l) begin
            pop_count++;
            last_pop_cyc = cyc;
            check("pop_context", 32'(!busy_l || (xfer && last_l)), 32'd1);
        end
        if (prev_valid && !prev_xfer) begin
            check("stall_valid", 32'(valid_l), 32'd1);
            check("stall_byte", 32'(byte_l), 32'(prev_byte));
            check("stall_last", 32'(last_l), 32'(prev_last));
        end
        if (xfer) begin
            xfer_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", 32'(byte_l), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("byte_lsb_first", 32'(byte_l), 32'(e.lsb));
                check("byte_msb_first", 32'(byte_m), 32'(e.msb));
                check("last_lsb_first", 32'(last_l), 32'(e.last));
                check("last_msb_first", 32'(last_m), 32'(e.last));
                if (strict) begin
                    if (e.first) check("first_byte_latency", 32'(cyc - last_pop_cyc), 32'd2);
                    else         check("byte_spacing", 32'(cyc - prev_xfer_cyc), 32'd1);
                end
            end
            prev_xfer_cyc = cyc;
        end
        prev_valid = valid_l;
        prev_xfer  = xfer;
        prev_byte  = byte_l;
        prev_last  = last_l;
    endtask

    // One clock: check at the falling edge, then update the FIFO model just after the rise.
    task automatic tick();
        bit pop_s, rst_s;
        @(negedge clk);
        monitor();
        pop_s = pop_l;
        rst_s = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) fifo_q.delete();
        else if (pop_s && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && (exp_q.size() != 0 || busy_l); n++) tick();
        check("drain_timeout", 32'(exp_q.size() == 0 && !busy_l), 32'd1);
    endtask

    initial begin
        int p0, x0, nw;

        // Reset: outputs idle and no pop even if the FIFO claims data.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        fifo_empty = 1'b0;
        #1;
        check("pop_in_reset", 32'(pop_l), 32'd0);
        check("reset_valid", 32'(valid_l), 32'd0);
        check("reset_byte", 32'(byte_l), 32'd0);
        check("reset_last", 32'(last_l), 32'd0);
        check("reset_busy", 32'(busy_l), 32'd0);
        fifo_empty = 1'b1;
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy_l), 32'd0);

        // Single word, ready high, both byte orders.
        strict = 1'b1;
        byte_ready = 1'b1;
        p0 = pop_count;
        push_word(32'hA1B2C3D4);
        wait_drain(30);
        check("single_word_pops", 32'(pop_count - p0), 32'd1);
        check("single_word_idle", 32'(busy_l), 32'd0);

        // Eight back-to-back words.
        p0 = pop_count;
        for (int i = 0; i < 8; i++) push_word(32'h1000_0000 * (i + 1) + 32'h0102_0304 * i + 32'h5A);
        wait_drain(100);
        check("burst_pops", 32'(pop_count - p0), 32'd8);

        // Backpressure.
        strict = 1'b0;
        byte_ready = 1'b0;
        p0 = pop_count;
        x0 = xfer_count;
        push_word(32'h11223344);
        for (int n = 0; n < 10 && !valid_l; n++) tick();
        check("valid_rise", 32'(valid_l), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold_lsb", 32'(byte_l), 32'h44);
            check("stall_hold_msb", 32'(byte_m), 32'h11);
        end
        for (int i = 0; i < 4; i++) begin
            byte_ready = (i % 2 == 0);
            tick();
        end
        byte_ready = 1'b1;
        wait_drain(30);
        check("bp_xfers", 32'(xfer_count - x0), 32'd4);
        check("bp_pops", 32'(pop_count - p0), 32'd1);

        // Reset in the middle of a word.
        strict = 1'b1;
        x0 = xfer_count;
        push_word(32'hDEADBEEF);
        for (int n = 0; n < 20 && xfer_count < x0 + 2; n++) tick();
        check("two_bytes_sent", 32'(xfer_count - x0), 32'd2);
        rst = 1'b1;
        byte_ready = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        byte_ready = 1'b1;
        #1;
        check("midreset_valid", 32'(valid_l), 32'd0);
        check("midreset_byte", 32'(byte_l), 32'd0);
        check("midreset_busy", 32'(busy_l), 32'd0);
        p0 = pop_count;
        for (int i = 0; i < 5; i++) tick();
        check("midreset_no_pop", 32'(pop_count - p0), 32'd0);
        push_word(32'h01020304);
        wait_drain(30);

        // Empty FIFO with ready high.
        for (int i = 0; i < 20; i++) begin
            check("empty_pop", 32'(pop_l), 32'd0);
            check("empty_valid", 32'(valid_l), 32'd0);
            check("empty_busy", 32'(busy_l), 32'd0);
            tick();
        end

        // Random words under random backpressure.
        strict = 1'b0;
        for (int r = 0; r < 30; r++) begin
            p0 = pop_count;
            nw = $urandom_range(1, 8);
            for (int i = 0; i < nw; i++) push_word($urandom);
            for (int n = 0; n < 400 && (exp_q.size() != 0 || busy_l); n++) begin
                byte_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            check("rand_drain", 32'(exp_q.size() == 0 && !busy_l), 32'd1);
            check("rand_pops", 32'(pop_count - p0), 32'(nw));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
